// File: rtl/ov2640_sccb_config.sv
// OV2640 configuration sequencer: walks the register LUT and sends each {reg,data}
// command as a 3-phase SCCB write (device ID, register, data) on sio_c/sio_d.
module ov2640_sccb_config #(
    parameter logic [7:0] DEV_ID    = 8'h60,
    parameter int         CLK_DIV   = 250,
    parameter int         RST_DELAY = 250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cfg_cmd,
    input  logic        cfg_finished,
    output logic        cfg_resend,
    output logic        cfg_advance,
    output logic        sio_c,
    output logic        sio_d_out,
    output logic        sio_d_oe,
    output logic        busy,
    output logic        done,
    output logic [8:0]  cmd_count
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = (RST_DELAY > 1) ? $clog2(RST_DELAY) : 1;
    localparam logic [QW-1:0] QDIV_LAST = QW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DLY_LAST  = DW'(RST_DELAY - 1);
    localparam logic [15:0]   CMD_SOFT_RESET = 16'h1280;

    typedef enum logic [3:0] {
        S_IDLE, S_RESEND, S_WAIT_LUT, S_CHECK, S_START, S_BITS,
        S_STOP, S_POST, S_DELAY, S_ADV, S_DONE
    } state_t;

    state_t          state_q;
    logic [QW-1:0]   qdiv_q;
    logic [1:0]      quarter_q;
    logic [4:0]      bit_q;
    logic [26:0]     frame_q;
    logic [15:0]     cmd_q;
    logic            wait_q;
    logic [DW-1:0]   delay_q;
    logic            cfg_resend_q, cfg_advance_q;
    logic            sio_c_q, sio_d_out_q, sio_d_oe_q;
    logic            busy_q, done_q;
    logic [8:0]      cmd_count_q;

    logic            tick;
    logic [26:0]     frame_d;

    // The 9th bit of each phase is the slave ACK slot: line released.
    assign frame_d = {DEV_ID, 1'b1, cfg_cmd[15:8], 1'b1, cfg_cmd[7:0], 1'b1};
    assign tick    = (qdiv_q == QDIV_LAST);

    function automatic logic is_ack(input logic [4:0] b);
        return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            qdiv_q        <= '0;
            quarter_q     <= 2'd0;
            bit_q         <= 5'd0;
            frame_q       <= '0;
            cmd_q         <= 16'd0;
            wait_q        <= 1'b0;
            delay_q       <= '0;
            cfg_resend_q  <= 1'b0;
            cfg_advance_q <= 1'b0;
            sio_c_q       <= 1'b1;
            sio_d_out_q   <= 1'b1;
            sio_d_oe_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cmd_count_q   <= 9'd0;
        end else if (start) begin
            // Abort whatever is in flight without a STOP and rewind the LUT.
            state_q       <= S_RESEND;
            qdiv_q        <= '0;
            cfg_resend_q  <= 1'b1;
            cfg_advance_q <= 1'b0;
            sio_c_q       <= 1'b1;
            sio_d_out_q   <= 1'b1;
            sio_d_oe_q    <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            cmd_count_q   <= 9'd0;
        end else begin
            cfg_resend_q  <= 1'b0;
            cfg_advance_q <= 1'b0;
            case (state_q)
                S_IDLE: ;
                S_RESEND: begin
                    state_q <= S_WAIT_LUT;
                    wait_q  <= 1'b0;
                end
                S_WAIT_LUT: begin
                    wait_q <= 1'b1;
                    if (wait_q) state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (cfg_finished) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cmd_q       <= cfg_cmd;
                        frame_q     <= frame_d;
                        state_q     <= S_START;
                        quarter_q   <= 2'd0;
                        qdiv_q      <= '0;
                        sio_c_q     <= 1'b1;
                        sio_d_oe_q  <= 1'b1;
                        sio_d_out_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        qdiv_q <= '0;
                        if (quarter_q == 2'd0) begin
                            quarter_q <= 2'd1;
                            sio_c_q   <= 1'b0;
                        end else begin
                            state_q     <= S_BITS;
                            quarter_q   <= 2'd0;
                            bit_q       <= 5'd0;
                            sio_d_out_q <= frame_q[26];
                            sio_d_oe_q  <= 1'b1;
                            frame_q     <= {frame_q[25:0], 1'b0};
                        end
                    end else begin
                        qdiv_q <= qdiv_q + 1'b1;
                    end
                end
                S_BITS: begin
                    if (tick) begin
                        qdiv_q    <= '0;
                        quarter_q <= quarter_q + 2'd1;
                        case (quarter_q)
                            2'd1: sio_c_q <= 1'b1;
                            2'd3: begin
                                // Data only moves together with the falling SCL edge.
                                sio_c_q <= 1'b0;
                                if (bit_q == 5'd26) begin
                                    state_q     <= S_STOP;
                                    sio_d_oe_q  <= 1'b1;
                                    sio_d_out_q <= 1'b0;
                                end else begin
                                    bit_q       <= bit_q + 5'd1;
                                    sio_d_out_q <= frame_q[26];
                                    sio_d_oe_q  <= !is_ack(bit_q + 5'd1);
                                    frame_q     <= {frame_q[25:0], 1'b0};
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        qdiv_q <= qdiv_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        qdiv_q <= '0;
                        case (quarter_q)
                            2'd0: begin
                                quarter_q <= 2'd1;
                                sio_c_q   <= 1'b1;
                            end
                            2'd1: begin
                                quarter_q   <= 2'd2;
                                sio_d_oe_q  <= 1'b0;
                                sio_d_out_q <= 1'b1;
                            end
                            default: state_q <= S_POST;
                        endcase
                    end else begin
                        qdiv_q <= qdiv_q + 1'b1;
                    end
                end
                S_POST: begin
                    if (cmd_q == CMD_SOFT_RESET) begin
                        state_q <= S_DELAY;
                        delay_q <= '0;
                    end else begin
                        state_q       <= S_ADV;
                        cfg_advance_q <= 1'b1;
                        if (cmd_count_q != 9'h1FF) cmd_count_q <= cmd_count_q + 9'd1;
                    end
                end
                S_DELAY: begin
                    // Sensor needs time to come out of its soft reset.
                    if (delay_q == DLY_LAST) begin
                        state_q       <= S_ADV;
                        cfg_advance_q <= 1'b1;
                        if (cmd_count_q != 9'h1FF) cmd_count_q <= cmd_count_q + 9'd1;
                    end else begin
                        delay_q <= delay_q + 1'b1;
                    end
                end
                S_ADV: begin
                    state_q <= S_WAIT_LUT;
                    wait_q  <= 1'b0;
                end
                S_DONE: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_resend  = cfg_resend_q;
    assign cfg_advance = cfg_advance_q;
    assign sio_c       = sio_c_q;
    assign sio_d_out   = sio_d_out_q;
    assign sio_d_oe    = sio_d_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cmd_count   = cmd_count_q;

endmodule

// File: tb/tb_ov2640_sccb_config.sv
// Bench for ov2640_sccb_config: LUT model drives the DUT, a bus monitor decodes
// SCCB frames and checks them against a scoreboard of expected commands.
module tb_ov2640_sccb_config;

    localparam int CD = 2;
    localparam int RD = 10;
    localparam logic [26:0] OE_MASK = 27'b111111110_111111110_111111110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_cmd;
    logic        cfg_finished;
    logic        cfg_resend, cfg_advance, sio_c, sio_d_out, sio_d_oe, busy, done;
    logic [8:0]  cmd_count;

    ov2640_sccb_config #(.DEV_ID(8'h60), .CLK_DIV(CD), .RST_DELAY(RD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_cmd(cfg_cmd),
        .cfg_finished(cfg_finished), .cfg_resend(cfg_resend), .cfg_advance(cfg_advance),
        .sio_c(sio_c), .sio_d_out(sio_d_out), .sio_d_oe(sio_d_oe),
        .busy(busy), .done(done), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    // LUT model: registered address, registered command output (2-cycle latency).
    logic [15:0] lut [0:7];
    logic [2:0]  lut_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_addr <= 3'd0;
            cfg_cmd  <= 16'hFFFF;
        end else begin
            if (cfg_resend) lut_addr <= 3'd0;
            else if (cfg_advance) lut_addr <= lut_addr + 3'd1;
            cfg_cmd <= lut[lut_addr];
        end
    end
    assign cfg_finished = (cfg_cmd == 16'hFFFF);

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] cmd;
        bit          abort;
        int          gap;
    } exp_t;
    exp_t exp_q[$];

    task automatic push(input logic [15:0] c, input bit ab);
        exp_t e;
        e.cmd   = c;
        e.abort = ab;
        e.gap   = (c == 16'h1280) ? (CD + 1 + RD) : (CD + 1);
        exp_q.push_back(e);
    endtask

    function automatic logic [26:0] exp_bits(input logic [15:0] c);
        return {8'h60, 1'b1, c[15:8], 1'b1, c[7:0], 1'b1};
    endfunction

    // Monitor state shared with the stimulus process (read-only there).
    longint      cyc = 0;
    int          mon_starts = 0;
    int          nbits = 0;
    bit          in_frame = 0;
    logic [26:0] got_bits, got_oe;
    longint      start_cyc, stop_cyc, kick_cyc;
    bit          pend = 0, kick_valid = 0;
    int          pend_gap;
    int          frame_no = 0;

    task automatic abort_pop();
        exp_t e;
        chk("sb_nonempty", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("abort_flag", e.abort, 1);
            chk("abort_prefix", got_bits, exp_bits(e.cmd) >> (27 - nbits));
            $display("frame %0d aborted after %0d bits (cmd %04h)", frame_no, nbits, e.cmd);
            frame_no++;
        end
    endtask

    task automatic frame_pop();
        exp_t e;
        chk("sb_nonempty", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_nbits", nbits, 27);
            chk("frame_abort_flag", e.abort, 0);
            chk("frame_bits", got_bits, exp_bits(e.cmd));
            chk("frame_oe", got_oe, OE_MASK);
            // Stop condition appears at the start of the last quarter.
            chk("frame_len", cyc - start_cyc + CD, 113 * CD);
            $display("frame %0d cmd=%04h bits=%b oe=%b len=%0d", frame_no, e.cmd,
                     got_bits, got_oe, cyc - start_cyc + CD);
            frame_no++;
            pend     = 1;
            pend_gap = e.gap;
            stop_cyc = cyc;
        end
    endtask

    initial begin : monitor
        logic sda, prev_c, prev_sda, adv_prev;
        prev_c = 1'b1;
        prev_sda = 1'b1;
        adv_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            sda = sio_d_oe ? sio_d_out : 1'b1;
            if (adv_prev) chk("adv_width", cfg_advance, 0);
            adv_prev = cfg_advance;
            if (cfg_advance) chk("adv_excl_resend", cfg_resend, 0);
            if (!rst_n || cfg_resend) begin
                if (in_frame) abort_pop();
                in_frame   = 0;
                pend       = 0;
                kick_valid = cfg_resend;
                kick_cyc   = cyc;
            end else begin
                if (cfg_advance) begin
                    if (pend) chk("stop_to_adv_gap", cyc - stop_cyc, pend_gap);
                    pend       = 0;
                    kick_valid = 1;
                    kick_cyc   = cyc;
                end
                if (prev_c && sio_c && prev_sda && !sda) begin
                    chk("start_outside_frame", in_frame, 0);
                    if (kick_valid) chk("kick_to_start_gap", cyc - kick_cyc, 4);
                    kick_valid = 0;
                    in_frame   = 1;
                    nbits      = 0;
                    got_bits   = '0;
                    got_oe     = '0;
                    start_cyc  = cyc;
                    mon_starts++;
                end else if (in_frame && prev_c && sio_c && !prev_sda && sda) begin
                    frame_pop();
                    in_frame = 0;
                end else if (in_frame && !prev_c && sio_c && nbits < 27) begin
                    got_bits = {got_bits[25:0], sda};
                    got_oe   = {got_oe[25:0], sio_d_oe};
                    nbits++;
                end
            end
            prev_c   = sio_c;
            prev_sda = sda;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk(name, done, 1);
    endtask

    task automatic load_main_lut();
        lut[0] = 16'hFF01;
        lut[1] = 16'h1280;
        lut[2] = 16'hFF00;
        lut[3] = 16'hFFFF;
    endtask

    initial begin : stimulus
        int base, first_done;
        bit c_low, reached;
        for (int i = 0; i < 8; i++) lut[i] = 16'hFFFF;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_sio_c", sio_c, 1);
        chk("rst_sio_d_oe", sio_d_oe, 0);
        chk("rst_sio_d_out", sio_d_out, 1);
        chk("rst_resend_advance", {cfg_resend, cfg_advance}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_cmd_count", cmd_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full sequence with soft-reset settle delay
        load_main_lut();
        push(16'hFF01, 0);
        push(16'h1280, 0);
        push(16'hFF00, 0);
        pulse_start();
        chk("busy_after_start", busy, 1);
        wait_done("seq_done");
        chk("seq_cmd_count", cmd_count, 3);
        chk("seq_busy_low", busy, 0);
        chk("seq_sb_empty", exp_q.size(), 0);

        // Single-frame bit decode
        lut[0] = 16'h2CFF;
        lut[1] = 16'hFFFF;
        push(16'h2CFF, 0);
        pulse_start();
        wait_done("decode_done");
        chk("decode_cmd_count", cmd_count, 1);
        chk("decode_sb_empty", exp_q.size(), 0);

        // Empty LUT: no frames, quick done
        lut[0] = 16'hFFFF;
        c_low = 0;
        first_done = 0;
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            if (!sio_c) c_low = 1;
            if (done && first_done == 0) first_done = i;
            @(negedge clk);
        end
        chk("empty_done_within5", longint'(first_done >= 1 && first_done <= 5), 1);
        chk("empty_cmd_count", cmd_count, 0);
        chk("empty_sio_c_low_seen", c_low, 0);

        // Restart during bit 12 of the second frame
        load_main_lut();
        push(16'hFF01, 0);
        push(16'h1280, 1);
        base = mon_starts;
        pulse_start();
        reached = 0;
        for (int i = 0; i < 2000; i++) begin
            if (mon_starts >= base + 2 && in_frame && nbits >= 12) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_point_reached", reached, 1);
        push(16'hFF01, 0);
        push(16'h1280, 0);
        push(16'hFF00, 0);
        pulse_start();
        chk("abort_sio_c_idle", sio_c, 1);
        chk("abort_oe_released", sio_d_oe, 0);
        chk("abort_resend_pulse", cfg_resend, 1);
        chk("abort_cmd_count_zero", cmd_count, 0);
        wait_done("abort_done");
        chk("abort_cmd_count", cmd_count, 3);
        chk("abort_sb_empty", exp_q.size(), 0);

        // Asynchronous reset mid-frame
        push(16'hFF01, 1);
        base = mon_starts;
        pulse_start();
        reached = 0;
        for (int i = 0; i < 2000; i++) begin
            if (mon_starts > base && in_frame && nbits >= 5) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reset_point_reached", reached, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_sio_c", sio_c, 1);
        chk("midrst_oe", sio_d_oe, 0);
        chk("midrst_busy_done", {busy, done}, 0);
        chk("midrst_cmd_count", cmd_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
